perspective_divide: RTL and testbench
=====================================

# perspective_divide

Post-transform stage that sits directly downstream of the vertex transform stage. It takes the three clip-space vertices (x, y, z, w in signed Q16.16) of one triangle, computes 1/w per vertex with an iterative divider, and applies the perspective divide and viewport mapping. It outputs screen-space coordinates and 1/w to the rasterizer setup stage. Triangles with any w ≤ 0 are culled.

## Interface
- VP_W, 640, viewport width in pixels (integer, ≤ 4095)
- VP_H, 480, viewport height in pixels (integer, ≤ 4095)

- clock  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-low reset
- x_in[3:0], y_in[3:0], z_in[3:0], w_in[3:0]  in  32 each  clip-space vertices, Q16.16 signed; entries 0..2 used, entry 3 ignored
- input_data_valid  in  1  upstream triangle present
- done_in  in  1  upstream stream finished (level)
- stall_in  in  1  downstream cannot accept
- sx_out[2:0], sy_out[2:0], sz_out[2:0]  out  32 each  screen-space coordinates, Q16.16
- inv_w_out[2:0]  out  32 each  1/w, Q16.16 unsigned
- out_data_valid  out  1  output triangle valid
- culled  out  1  one-cycle pulse: accepted triangle was dropped
- stall_out  out  1  block busy; upstream must hold
- done_out  out  1  stream finished and block drained

## Operation
- States: IDLE, DIV, SCALE, OUT. Vertex index vi counts 0..2.
- IDLE: stall_out=0. If input_data_valid=1, the block accepts on that edge and latches all x/y/z/w[0..2].
  - If any latched w has bit31=1 or equals 0: pulse culled, stay IDLE.
  - Otherwise: vi=0, go to DIV.
- DIV: unsigned restoring division of the 33-bit dividend 2^32 by w[vi].
  - One quotient bit per cycle, 33 cycles.
  - If the quotient exceeds 0x7FFFFFFF, the result saturates to 0x7FFFFFFF.
  - The result goes to inv_w[vi], then the state goes to SCALE.
- SCALE (1 cycle), with r = inv_w[vi] and all products full 64-bit signed:
  - nx = (x·r)[47:16], ny = (y·r)[47:16], nz = (z·r)[47:16]
  - sx = ((nx + 0x10000) · VP_W) >>> 1, keep low 32 bits
  - sy = ((0x10000 − ny) · VP_H) >>> 1, keep low 32 bits (y is flipped)
  - sz = nz
  - Overflow wraps; there is no clamping.
  - If vi<2: vi++ and go to DIV. Otherwise go to OUT.
- OUT: out_data_valid=1 and all outputs are held stable. The transfer completes on any edge with stall_in=0; the state then goes to IDLE and out_data_valid=0.
- stall_out = (state != IDLE). It is decoded directly from the state register, so it has no combinational path from any input.
- done_out: set when done_in=1 and state is IDLE with input_data_valid=0. It is sticky until reset.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state IDLE, vi=0
  - all data outputs 0
  - out_data_valid=0, culled=0, stall_out=0, done_out=0
- Latency: accept edge E0; out_data_valid rises at edge E0+102 (3 × (33 DIV + 1 SCALE)).
- Minimum triangle period is 104 cycles: 102 compute cycles, ≥1 cycle in OUT, and 1 cycle in IDLE before the next accept.
- culled is high for exactly one cycle, following the accept edge.
- stall_in is ignored outside OUT.
- Reset asserted in DIV, SCALE or OUT discards the triangle with no output. The first accept after release is processed normally.
- done_in and input_data_valid both high in IDLE: the triangle is accepted and done_out is not set. done_out sets only after the block returns to IDLE with input_data_valid=0.

## Test plan
- **Identity w.** w=0x00010000, x=0x8000, y=0x8000, z=0x8000, same for all three vertices, VP 640×480 → after 102 cycles: sx=0x01E00000 (480.0), sy=0x00780000 (120.0), sz=0x8000, inv_w=0x00010000.
- **w=2.0.** w=0x00020000, x=0x00010000, y=0, z=0 → inv_w=0x8000, sx=0x01E00000, sy=0x00F00000 (240.0), sz=0.
- **Cull.** Vertex 1 has w=0xFFFF0000 → culled high for 1 cycle, out_data_valid stays 0, stall_out stays 0. Also repeat with w=0 on vertex 2: same response.
- **Stall.** Hold stall_in=1 for 5 cycles in OUT → outputs and out_data_valid=1 stay stable and stall_out=1. Release → out_data_valid=0 after the next edge; the next triangle is accepted one cycle later.
- **Saturation.** w=0x00000001 → inv_w=0x7FFFFFFF. With x=0, sx=0x01400000 (320.0).
- **Reset mid-DIV, then done.** Assert reset during DIV → all outputs 0 and no output produced. After release, one full triangle completes. Then done_in=1 with input_data_valid=0 → done_out=1 on the next edge and remains set.

Source files
------------

// File: rtl/perspective_divide_if.sv
// Triangle handshake and data bus between the vertex transform, perspective divide and
// rasterizer setup stages.
interface perspective_divide_if;
    logic [3:0][31:0] x_in;
    logic [3:0][31:0] y_in;
    logic [3:0][31:0] z_in;
    logic [3:0][31:0] w_in;
    logic             input_data_valid;
    logic             done_in;
    logic             stall_in;
    logic [2:0][31:0] sx_out;
    logic [2:0][31:0] sy_out;
    logic [2:0][31:0] sz_out;
    logic [2:0][31:0] inv_w_out;
    logic             out_data_valid;
    logic             culled;
    logic             stall_out;
    logic             done_out;

    modport slave (
        input  x_in, y_in, z_in, w_in, input_data_valid, done_in, stall_in,
        output sx_out, sy_out, sz_out, inv_w_out, out_data_valid, culled, stall_out, done_out
    );

    modport master (
        output x_in, y_in, z_in, w_in, input_data_valid, done_in, stall_in,
        input  sx_out, sy_out, sz_out, inv_w_out, out_data_valid, culled, stall_out, done_out
    );
endinterface

// File: rtl/perspective_divide.sv
// Per-triangle 1/w via a restoring divider, then perspective divide and viewport mapping.
// Triangles with any w <= 0 are culled at accept time.
module perspective_divide #(
    parameter int unsigned VP_W = 640,
    parameter int unsigned VP_H = 480
) (
    input logic                 clock,
    input logic                 reset,
    perspective_divide_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDiv   = 2'd1;
    localparam logic [1:0] StScale = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    localparam logic [63:0] VpW64 = 64'(VP_W);
    localparam logic [63:0] VpH64 = 64'(VP_H);

    logic [1:0]       state_q;
    logic [1:0]       vi_q;
    logic [5:0]       cnt_q;
    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [2:0][31:0] x_q, y_q, z_q, w_q;
    logic [2:0][31:0] sx_q, sy_q, sz_q, inv_w_q;
    logic             culled_q;
    logic             done_q;

    logic        cull;
    logic [31:0] w_cur;
    logic [32:0] rem_shift, rem_nxt, quo_nxt;
    logic        rem_ge;
    logic [31:0] inv_nxt;
    logic [31:0] xv, yv, zv, r;
    logic [47:0] px, py, pz;
    logic [31:0] nx, ny;
    logic [32:0] ax, ay;

    always_comb begin
        cull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.w_in[i][31] || (bus.w_in[i] == 32'h0)) cull = 1'b1;
        end
    end

    // Dividend is 2^32: only the first of the 33 shifted-in bits is a one.
    always_comb begin
        w_cur     = w_q[vi_q];
        rem_shift = {rem_q, (cnt_q == 6'd0)};
        rem_ge    = rem_shift >= {1'b0, w_cur};
        rem_nxt   = rem_ge ? (rem_shift - {1'b0, w_cur}) : rem_shift;
        quo_nxt   = {quo_q, rem_ge};
        inv_nxt   = (quo_nxt[32:31] != 2'b00) ? 32'h7FFF_FFFF : quo_nxt[31:0];
    end

    // Low 64 bits of a product are the same signed or unsigned, so sign-extend and multiply.
    always_comb begin
        xv = x_q[vi_q];
        yv = y_q[vi_q];
        zv = z_q[vi_q];
        r  = inv_w_q[vi_q];
        px = 48'({{32{xv[31]}}, xv} * {32'h0, r});
        py = 48'({{32{yv[31]}}, yv} * {32'h0, r});
        pz = 48'({{32{zv[31]}}, zv} * {32'h0, r});
        nx = px[47:16];
        ny = py[47:16];
        ax = 33'(({{32{nx[31]}}, nx} + 64'h1_0000) * VpW64);
        ay = 33'((64'h1_0000 - {{32{ny[31]}}, ny}) * VpH64);
    end

    logic unused_bits;
    assign unused_bits = ^{px[15:0], py[15:0], pz[15:0], ax[0], ay[0], rem_nxt[32],
                           bus.x_in[3], bus.y_in[3], bus.z_in[3], bus.w_in[3]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            vi_q     <= 2'd0;
            cnt_q    <= 6'd0;
            rem_q    <= '0;
            quo_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            w_q      <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            sz_q     <= '0;
            inv_w_q  <= '0;
            culled_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            culled_q <= 1'b0;
            if (state_q == StIdle && bus.done_in && !bus.input_data_valid) done_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (bus.input_data_valid) begin
                        x_q <= bus.x_in[2:0];
                        y_q <= bus.y_in[2:0];
                        z_q <= bus.z_in[2:0];
                        w_q <= bus.w_in[2:0];
                        if (cull) begin
                            culled_q <= 1'b1;
                        end else begin
                            vi_q    <= 2'd0;
                            cnt_q   <= 6'd0;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            state_q <= StDiv;
                        end
                    end
                end
                StDiv: begin
                    rem_q <= rem_nxt[31:0];
                    quo_q <= quo_nxt[31:0];
                    if (cnt_q == 6'd32) begin
                        inv_w_q[vi_q] <= inv_nxt;
                        state_q       <= StScale;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StScale: begin
                    sx_q[vi_q] <= ax[32:1];
                    sy_q[vi_q] <= ay[32:1];
                    sz_q[vi_q] <= pz[47:16];
                    if (vi_q == 2'd2) begin
                        state_q <= StOut;
                    end else begin
                        vi_q    <= vi_q + 2'd1;
                        cnt_q   <= 6'd0;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        state_q <= StDiv;
                    end
                end
                StOut: begin
                    if (!bus.stall_in) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sx_out         = sx_q;
    assign bus.sy_out         = sy_q;
    assign bus.sz_out         = sz_q;
    assign bus.inv_w_out      = inv_w_q;
    assign bus.out_data_valid = (state_q == StOut);
    assign bus.stall_out      = (state_q != StIdle);
    assign bus.culled         = culled_q;
    assign bus.done_out       = done_q;

endmodule

// File: tb/tb_perspective_divide.sv
// Directed bench for perspective_divide: expected triangles are queued at drive time and
// checked when the block presents them.
module tb_perspective_divide;

    typedef struct packed {
        logic [2:0][31:0] sx;
        logic [2:0][31:0] sy;
        logic [2:0][31:0] sz;
        logic [2:0][31:0] iw;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    perspective_divide_if bus ();

    perspective_divide #(
        .VP_W(640),
        .VP_H(480)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0][31:0] x, y, z, w);
        exp_t   e;
        longint r, nx, ny, nz, ax, ay;
        logic [63:0] t;
        for (int i = 0; i < 3; i++) begin
            r = longint'(64'h1_0000_0000 / {32'h0, w[i]});
            if (r > 64'sh7FFF_FFFF) r = 64'sh7FFF_FFFF;
            t  = 64'(longint'($signed(x[i])) * r);
            nx = longint'($signed(t[47:16]));
            t  = 64'(longint'($signed(y[i])) * r);
            ny = longint'($signed(t[47:16]));
            t  = 64'(longint'($signed(z[i])) * r);
            nz = longint'($signed(t[47:16]));
            ax = ((nx + 65536) * 640) >>> 1;
            ay = ((65536 - ny) * 480) >>> 1;
            e.sx[i] = ax[31:0];
            e.sy[i] = ay[31:0];
            e.sz[i] = nz[31:0];
            e.iw[i] = r[31:0];
        end
        return e;
    endfunction

    task automatic drive_tri(input logic [3:0][31:0] x, y, z, w, input bit push, input bit dn);
        @(negedge clock);
        bus.x_in = x;
        bus.y_in = y;
        bus.z_in = z;
        bus.w_in = w;
        bus.done_in = dn;
        bus.input_data_valid = 1'b1;
        if (push) sb.push_back(model(x, y, z, w));
        @(posedge clock);
        #1;
        bus.input_data_valid = 1'b0;
        bus.done_in = 1'b0;
    endtask

    // Call right after drive_tri: counts edges from the accept edge to out_data_valid.
    task automatic wait_out(input string tag);
        int n = 0;
        while (!bus.out_data_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd102);
        if (bus.out_data_valid) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                last = sb.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("%s_sx%0d", tag, i), bus.sx_out[i], last.sx[i]);
                    chk($sformatf("%s_sy%0d", tag, i), bus.sy_out[i], last.sy[i]);
                    chk($sformatf("%s_sz%0d", tag, i), bus.sz_out[i], last.sz[i]);
                    chk($sformatf("%s_iw%0d", tag, i), bus.inv_w_out[i], last.iw[i]);
                end
            end
        end
    endtask

    logic [3:0][31:0] vx, vy, vz, vw;
    int               seen;

    initial begin
        bus.x_in = '0;
        bus.y_in = '0;
        bus.z_in = '0;
        bus.w_in = '0;
        bus.input_data_valid = 1'b0;
        bus.done_in = 1'b0;
        bus.stall_in = 1'b0;

        #1;
        chk("rst_sx0", bus.sx_out[0], 32'h0);
        chk("rst_iw2", bus.inv_w_out[2], 32'h0);
        chk("rst_valid", 32'(bus.out_data_valid), 32'd0);
        chk("rst_culled", 32'(bus.culled), 32'd0);
        chk("rst_stall", 32'(bus.stall_out), 32'd0);
        chk("rst_done", 32'(bus.done_out), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Identity w
        vx = {4{32'h0000_8000}};
        vy = {4{32'h0000_8000}};
        vz = {4{32'h0000_8000}};
        vw = {4{32'h0001_0000}};
        drive_tri(vx, vy, vz, vw, 1'b1, 1'b0);
        chk("id_busy", 32'(bus.stall_out), 32'd1);
        wait_out("id");
        chk("id_sx_lit", bus.sx_out[1], 32'h01E0_0000);
        chk("id_sy_lit", bus.sy_out[1], 32'h0078_0000);
        chk("id_sz_lit", bus.sz_out[1], 32'h0000_8000);
        chk("id_iw_lit", bus.inv_w_out[1], 32'h0001_0000);
        @(posedge clock);
        #1;
        chk("id_valid_drop", 32'(bus.out_data_valid), 32'd0);

        // w = 2.0
        vx = {4{32'h0001_0000}};
        vy = '0;
        vz = '0;
        vw = {4{32'h0002_0000}};
        drive_tri(vx, vy, vz, vw, 1'b1, 1'b0);
        wait_out("w2");
        chk("w2_iw_lit", bus.inv_w_out[0], 32'h0000_8000);
        chk("w2_sy_lit", bus.sy_out[2], 32'h00F0_0000);
        @(posedge clock);
        #1;

        // Cull: negative w on vertex 1, then zero w on vertex 2
        vw = {32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000};
        drive_tri(vx, vy, vz, vw, 1'b0, 1'b0);
        chk("cull1_pulse", 32'(bus.culled), 32'd1);
        chk("cull1_stall", 32'(bus.stall_out), 32'd0);
        chk("cull1_valid", 32'(bus.out_data_valid), 32'd0);
        @(posedge clock);
        #1;
        chk("cull1_pulse_end", 32'(bus.culled), 32'd0);
        vw = {32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000};
        drive_tri(vx, vy, vz, vw, 1'b0, 1'b0);
        chk("cull2_pulse", 32'(bus.culled), 32'd1);
        chk("cull2_stall", 32'(bus.stall_out), 32'd0);
        @(posedge clock);
        #1;
        chk("cull2_pulse_end", 32'(bus.culled), 32'd0);
        chk("cull2_valid", 32'(bus.out_data_valid), 32'd0);

        // Stall held in OUT, then back-to-back accept
        bus.stall_in = 1'b1;
        vx = {32'h0, 32'h0000_199A, 32'h0002_4000, 32'hFFFE_8000};
        vy = {32'h0, 32'h0000_3000, 32'hFFFF_0000, 32'h0000_8000};
        vz = {32'h0, 32'h0000_C000, 32'h0000_8000, 32'h0000_4000};
        vw = {32'h0, 32'h0007_0000, 32'h0000_8000, 32'h0003_0000};
        drive_tri(vx, vy, vz, vw, 1'b1, 1'b0);
        wait_out("stall");
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("stall_hold_valid%0d", k), 32'(bus.out_data_valid), 32'd1);
            chk($sformatf("stall_hold_busy%0d", k), 32'(bus.stall_out), 32'd1);
            chk($sformatf("stall_hold_sx%0d", k), bus.sx_out[0], last.sx[0]);
            chk($sformatf("stall_hold_iw%0d", k), bus.inv_w_out[2], last.iw[2]);
        end
        bus.stall_in = 1'b0;
        @(posedge clock);
        #1;
        chk("stall_release_valid", 32'(bus.out_data_valid), 32'd0);
        chk("stall_release_busy", 32'(bus.stall_out), 32'd0);
        vx = {4{32'h0000_4000}};
        vy = {4{32'hFFFF_C000}};
        vz = {4{32'h0001_0000}};
        vw = {4{32'h0000_C000}};
        drive_tri(vx, vy, vz, vw, 1'b1, 1'b0);
        chk("b2b_accepted", 32'(bus.stall_out), 32'd1);
        wait_out("b2b");
        @(posedge clock);
        #1;

        // Saturation, with done_in raised together with the accept
        vx = '0;
        vy = '0;
        vz = '0;
        vw = {4{32'h0000_0001}};
        drive_tri(vx, vy, vz, vw, 1'b1, 1'b1);
        chk("sat_no_done", 32'(bus.done_out), 32'd0);
        wait_out("sat");
        chk("sat_iw_lit", bus.inv_w_out[1], 32'h7FFF_FFFF);
        chk("sat_sx_lit", bus.sx_out[1], 32'h0140_0000);
        @(posedge clock);
        #1;

        // Reset during DIV discards the triangle
        vx = {4{32'h0003_0000}};
        vy = {4{32'h0001_0000}};
        vz = {4{32'h0000_2000}};
        vw = {4{32'h0004_0000}};
        drive_tri(vx, vy, vz, vw, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        chk("mid_div_busy", 32'(bus.stall_out), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_sx0", bus.sx_out[0], 32'h0);
        chk("arst_iw1", bus.inv_w_out[1], 32'h0);
        chk("arst_sy2", bus.sy_out[2], 32'h0);
        chk("arst_stall", 32'(bus.stall_out), 32'd0);
        chk("arst_valid", 32'(bus.out_data_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (150) begin
            @(posedge clock);
            #1;
            if (bus.out_data_valid) seen++;
        end
        chk("arst_no_output", 32'(seen), 32'd0);
        drive_tri(vx, vy, vz, vw, 1'b1, 1'b0);
        wait_out("post_rst");
        @(posedge clock);
        #1;

        // done_out: sticky once set from IDLE with no valid input
        chk("done_before", 32'(bus.done_out), 32'd0);
        @(negedge clock);
        bus.done_in = 1'b1;
        @(posedge clock);
        #1;
        chk("done_set", 32'(bus.done_out), 32'd1);
        bus.done_in = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("done_sticky", 32'(bus.done_out), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
